// File: rtl/fetch_sequencer_pkg.sv
//------------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the fetch sequencer slice
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
//------------------------------------------------------------------------------
// fetch_sequencer_if : imem, decode, redirect and halt signals of the fetch unit
// Rev 1.0   (FETCH_PERF_CNT_EN adds the performance counter signals)
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt_req;
  logic              halted;
  logic              misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
           perf_fetched, perf_stall,
    input  imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
           perf_fetched, perf_stall,
    output imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );
`else
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
    input  imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
    output imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_queue.sv
//------------------------------------------------------------------------------
// fetch_queue : QDEPTH-entry prefetch FIFO (QDEPTH 2 or 4) with flush
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          i_push,
  input  fetch_entry_t i_push_data,
  input  wire          i_pop,
  input  wire          i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int               c_PTR_W = $clog2(QDEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(QDEPTH);

  fetch_entry_t       r_mem [QDEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_FULL);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// fetch_sequencer : PC, prefetch queue, redirect and halt control for fetch
// Rev 1.0   (optional counters enabled by FETCH_PERF_CNT_EN)
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8,
  parameter int          QDEPTH   = 2
) (
  input  wire                clk,
  input  wire                reset,
  fetch_sequencer_if.master  bus
);

  fetch_state_t r_state;
  logic         r_halted;
  logic         r_misalign;
  logic [31:0]  r_pc;

  fetch_entry_t w_head;
  fetch_entry_t w_push_data;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_fetch;

  // A redirect voids any pop in the same cycle: the head is flushed instead.
  assign w_pop   = !w_empty && bus.out_ready && !bus.redirect_valid;
  assign w_fetch = (r_state == RUN) && !bus.redirect_valid && (!w_full || w_pop);
  assign w_push_data = '{pc: r_pc, instr: bus.imem_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_fetch),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect_valid),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_pc       <= RESET_PC;
    end else begin
      if (bus.redirect_valid) begin
        r_pc <= {bus.redirect_pc[31:2], 2'b00};
        if (bus.redirect_pc[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end else if (w_fetch) begin
        r_pc <= r_pc + 32'd4;
      end

      case (r_state)
        RUN: begin
          if (bus.halt_req) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.halt_req) begin
            r_state <= RUN;
          end else if (w_empty) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
        end
        HALT: begin
          if (!bus.halt_req) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr    = r_pc[ADDR_W+1:2];
  assign bus.out_valid    = !w_empty;
  assign bus.out_instr    = w_head.instr;
  assign bus.out_pc       = w_head.pc;
  assign bus.halted       = r_halted;
  assign bus.misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fetch && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_full && !w_pop && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory: owns the PC and drives the word address.
- Captures each returned instruction into a 2-entry prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush) and a halt/resume request from the hazard/debug logic.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- ADDR_W, 8, instruction-memory word-index width (256 words).
- QDEPTH, 2, prefetch queue depth in entries; legal values are 2 and 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  word index to the instruction memory, equal to pc[ADDR_W+1:2].
- imem_rdata  in  32  instruction returned combinationally for imem_addr.
- out_valid  out  1  the queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  byte PC of the head instruction.
- redirect_valid  in  1  branch/jump taken; flush the queue and refetch.
- redirect_pc  in  32  new byte PC.
- halt_req  in  1  level request: stop fetching.
- halted  out  1  block is in HALT and the queue is empty.
- misalign_err  out  1  sticky flag: a redirect_pc with bits[1:0] != 0 was received.

Behaviour:
- Reset (reset high at an edge):
  - pc = RESET_PC; queue emptied; state = RUN.
  - out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, misalign_err = 0.
  - imem_addr follows pc combinationally.
  - Reset asserted mid-operation discards all queued entries and any pending redirect.
- Fetch:
  - A fetch occurs in a cycle when state == RUN, redirect_valid == 0, and either the queue is not full or a pop happens in the same cycle.
  - A fetch pushes {pc, imem_rdata} and sets pc = pc + 4. The 32-bit add wraps; imem_addr wraps modulo 2^ADDR_W words.
- Pop: the head is removed when out_valid && out_ready.
- Latency:
  - First fetch happens in the first cycle reset is low.
  - out_valid rises one cycle after reset deasserts.
  - Steady state sustains one instruction per cycle with out_ready held high.
- Full queue with no pop: no fetch and pc holds. Push and pop in the same cycle leave the occupancy unchanged.
- Redirect (redirect_valid high at edge t):
  - The queue is flushed, including the head even if out_ready was high; that pop is void.
  - pc = {redirect_pc[31:2], 2'b00}.
  - No push at t; fetch resumes at t+1; the target instruction appears at out_valid during t+2.
  - redirect_pc[1:0] != 0 sets misalign_err, which is cleared only by reset.
- State machine:
  - RUN -> DRAIN when halt_req = 1. Fetching stops; the queue continues to pop.
  - DRAIN -> HALT when the queue is empty.
  - DRAIN/HALT -> RUN when halt_req = 0. Fetch resumes the next cycle at the held pc.
  - halted = (state == HALT).
- Redirect during DRAIN or HALT: updates pc and flushes the queue; the state is unchanged.
- Simultaneous halt_req and redirect: both apply — pc is updated, the queue is flushed, and the state goes to DRAIN.
- out_instr and out_pc are registered queue outputs; there is no combinational path from imem_rdata to out_*.

Optional Feature:
- FETCH_PERF_CNT_EN:
  - Defined: adds outputs perf_fetched[31:0] (count of pushes) and perf_stall[31:0] (cycles with the queue full and no pop).
  - Both counters are cleared by reset and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_state_t {RUN, DRAIN, HALT}.
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
  - constant INSTR_NOP = 32'h0000_0013.
- One sub-module, fetch_queue: a parameterised QDEPTH FIFO of fetch_entry_t with push/pop/flush and full/empty outputs.
- The PC, FSM and error flag stay in the top module.

Test Plan:
- Memory words 0..3 = 0x11,0x22,0x33,0x44; reset released; out_ready=1 -> out_valid rises 1 cycle after reset deasserts; out_pc sequence 0,4,8,12 with matching instructions, one per cycle.
- out_ready=0 for 5 cycles after reset -> the queue fills to QDEPTH; pc holds at 4*QDEPTH; imem_addr stable; on release, instructions emerge in order with no loss or duplication.
- redirect_valid with redirect_pc=0x40 while the queue is full and out_ready=1 -> both entries flushed, no pop counted; out_valid=0 for 1 cycle; next out_pc=0x40.
- redirect_pc=0x42 -> misalign_err=1 and stays set; fetch proceeds from 0x40.
- halt_req held high with out_ready=1 -> remaining entries drain, halted=1, imem_addr frozen; halt_req drops -> fetch resumes at the held pc.
- Fetch at pc=0x3FC (word 255) -> next imem_addr=0 while out_pc=0x400; reset asserted mid-stream -> out_valid=0 next cycle and fetch restarts at RESET_PC.
